// File: rtl/bram_row_fetch.sv
// Fetches one 512-bit bitmap row as 16 sequential 32-bit BRAM reads over a
// trig/done handshake, then presents it MSB-word-first with a one-cycle valid pulse.
module bram_row_fetch #(
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_start,
  input  logic [8:0]   i_row_idx,
  output logic         o_busy,
  output logic [511:0] o_row_data,
  output logic         o_row_valid,
  output logic         o_err_timeout,
  output logic [12:0]  o_bram_addr,
  output logic         o_bram_trig,
  input  logic [31:0]  i_bram_data,
  input  logic         i_bram_done
);

  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [8:0]     r_row_q,     w_row_q_nxt;
  logic [3:0]     r_word_cnt,  w_word_cnt_nxt;
  logic [7:0]     r_to_cnt,    w_to_cnt_nxt;
  logic [511:0]   r_row_sr,    w_row_sr_nxt;
  logic [511:0]   r_row_data,  w_row_data_nxt;
  logic           r_busy,      w_busy_nxt;
  logic           r_valid,     w_valid_nxt;
  logic           r_err,       w_err_nxt;
  logic           r_trig,      w_trig_nxt;
  logic           w_to_hit;
  logic           w_last_word;

  assign w_to_hit    = (r_to_cnt == LP_TO_LAST);
  assign w_last_word = (r_word_cnt == 4'd15);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: w_state_nxt = i_start ? S_REQ : S_IDLE;
      S_REQ:  begin
        if (i_bram_done)   w_state_nxt = S_GAP;
        else if (w_to_hit) w_state_nxt = S_IDLE;
        else               w_state_nxt = S_REQ;
      end
      S_GAP:  w_state_nxt = w_last_word ? S_IDLE : S_REQ;
      default: w_state_nxt = S_IDLE;  // S_DONE is never entered
    endcase
  end

  // Next values for every registered output and datapath register.
  always_comb begin
    w_row_q_nxt    = r_row_q;
    w_word_cnt_nxt = r_word_cnt;
    w_to_cnt_nxt   = r_to_cnt;
    w_row_sr_nxt   = r_row_sr;
    w_row_data_nxt = r_row_data;
    w_busy_nxt     = r_busy;
    w_valid_nxt    = 1'b0;
    w_err_nxt      = r_err;
    w_trig_nxt     = r_trig;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_row_q_nxt    = i_row_idx;
          w_word_cnt_nxt = 4'd0;
          w_to_cnt_nxt   = 8'd0;
          w_err_nxt      = 1'b0;
          w_busy_nxt     = 1'b1;
          w_trig_nxt     = 1'b1;
        end
      end
      S_REQ: begin
        if (i_bram_done) begin
          w_row_sr_nxt = {r_row_sr[479:0], i_bram_data};
          w_trig_nxt   = 1'b0;
        end else if (w_to_hit) begin
          w_trig_nxt = 1'b0;
          w_err_nxt  = 1'b1;
          w_busy_nxt = 1'b0;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 8'd1;
        end
      end
      S_GAP: begin
        if (w_last_word) begin
          w_row_data_nxt = r_row_sr;
          w_valid_nxt    = 1'b1;
          w_busy_nxt     = 1'b0;
        end else begin
          w_word_cnt_nxt = r_word_cnt + 4'd1;
          w_to_cnt_nxt   = 8'd0;
          w_trig_nxt     = 1'b1;
        end
      end
      default: begin
        w_trig_nxt = 1'b0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_row_q    <= '0;
      r_word_cnt <= '0;
      r_to_cnt   <= '0;
      r_row_sr   <= '0;
      r_row_data <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_trig     <= 1'b0;
    end else begin
      r_row_q    <= w_row_q_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_row_sr   <= w_row_sr_nxt;
      r_row_data <= w_row_data_nxt;
      r_busy     <= w_busy_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
      r_trig     <= w_trig_nxt;
    end
  end

  assign o_busy        = r_busy;
  assign o_row_data    = r_row_data;
  assign o_row_valid   = r_valid;
  assign o_err_timeout = r_err;
  assign o_bram_addr   = {r_row_q, r_word_cnt};
  assign o_bram_trig   = r_trig;

endmodule
